issue_hazard_unit: RTL

- Sits between the decode stage (control decoder output) and the ID/EX pipeline register.
- Consumes the decoded control bits and register indices of the instruction in ID, and decides each cycle whether that instruction issues to EX, stalls IF/ID, or is replaced by a bubble.
- Tracks load-use hazards, one in-flight non-pipelined slow FPU op (fdiv/fsqrt class) with a per-register pending scoreboard, and I/O port readiness.
- Owns the slow-FPU writeback slot on the FP register file.

---
 rtl/issue_hazard_unit_if.sv | 49 ++++
 rtl/issue_hazard_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/issue_hazard_unit_if.sv
// ID-stage / hazard-unit handshake bundle: decoded control in, issue control and slow-FPU writeback out.
// Stats outputs exist only when ISSUE_HAZARD_STATS_EN is defined.
interface issue_hazard_unit_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_fp;
    logic       id_rs2_fp;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_fpu_reg_write;
    logic       id_mem_read;
    logic       id_slow_fpu_dispatch;
    logic       id_in_issued;
    logic       id_out_issued;
    logic       in_ready;
    logic       out_ready;
    logic       flush;
    logic       stall;
    logic       issue;
    logic       bubble;
    logic       slow_busy;
    logic       slow_wb_en;
    logic [4:0] slow_wb_rd;
`ifdef ISSUE_HAZARD_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_slow_ops;
`endif

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_fp, id_rs2_fp, id_rd, id_reg_write,
               id_fpu_reg_write, id_mem_read, id_slow_fpu_dispatch, id_in_issued,
               id_out_issued, in_ready, out_ready, flush,
        output stall, issue, bubble, slow_busy, slow_wb_en, slow_wb_rd
`ifdef ISSUE_HAZARD_STATS_EN
        , output stat_stall_cycles, stat_slow_ops
`endif
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_fp, id_rs2_fp, id_rd, id_reg_write,
               id_fpu_reg_write, id_mem_read, id_slow_fpu_dispatch, id_in_issued,
               id_out_issued, in_ready, out_ready, flush,
        input  stall, issue, bubble, slow_busy, slow_wb_en, slow_wb_rd
`ifdef ISSUE_HAZARD_STATS_EN
        , input stat_stall_cycles, stat_slow_ops
`endif
    );
endinterface

// File: rtl/issue_hazard_unit.sv
// Issue/stall/bubble decision for the ID instruction: load-use, slow-FPU scoreboard, I/O readiness.
// Optional stall/slow-op counters under ISSUE_HAZARD_STATS_EN.
module issue_hazard_unit #(
    parameter int SLOW_LAT = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    issue_hazard_unit_if.slave   hz
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         slow_rd_q, slow_rd_d;
    logic [31:0]        fp_pending_q, fp_pending_d;
    logic               ex_load_valid_q, ex_load_valid_d;
    logic [4:0]         ex_load_rd_q, ex_load_rd_d;
    logic               ex_load_fp_q, ex_load_fp_d;

    logic        busy, wb_en, cnt_zero, cnt_one;
    logic [31:0] wb_mask, pend_eff;
    logic        lu1, lu2, raw, waw, struct_hz, wbport_hz, io_hz, hazard;
    logic        stall, issue, slow_issue;

    always_comb begin
        busy     = (state_q == BUSY);
        cnt_zero = (cnt_q == '0);
        cnt_one  = (cnt_q == CNT_W'(1));
        wb_en    = busy & cnt_zero;
        wb_mask  = wb_en ? (32'd1 << slow_rd_q) : 32'd0;
        // FP RF is write-through, so the register being written back this cycle is already readable
        pend_eff = fp_pending_q & ~wb_mask;

        lu1 = ex_load_valid_q & (hz.id_rs1 == ex_load_rd_q) & (hz.id_rs1_fp == ex_load_fp_q)
              & (hz.id_rs1_fp | (hz.id_rs1 != 5'd0));
        lu2 = ex_load_valid_q & (hz.id_rs2 == ex_load_rd_q) & (hz.id_rs2_fp == ex_load_fp_q)
              & (hz.id_rs2_fp | (hz.id_rs2 != 5'd0));
        raw = (hz.id_rs1_fp & pend_eff[hz.id_rs1]) | (hz.id_rs2_fp & pend_eff[hz.id_rs2]);
        waw = hz.id_fpu_reg_write & pend_eff[hz.id_rd];
        struct_hz = hz.id_slow_fpu_dispatch & busy & ~cnt_zero;
        // a single-cycle FP write issued now would land on the slow writeback cycle
        wbport_hz = hz.id_fpu_reg_write & ~hz.id_slow_fpu_dispatch & busy & cnt_one;
        io_hz  = (hz.id_in_issued & ~hz.in_ready) | (hz.id_out_issued & ~hz.out_ready);
        hazard = lu1 | lu2 | raw | waw | struct_hz | wbport_hz | io_hz;

        stall      = rstn & ~hz.flush & hz.id_valid & hazard;
        issue      = rstn & ~hz.flush & hz.id_valid & ~hazard;
        slow_issue = issue & hz.id_slow_fpu_dispatch;
    end

    always_comb begin
        ex_load_valid_d = issue & hz.id_mem_read;
        ex_load_rd_d    = issue ? hz.id_rd : 5'd0;
        ex_load_fp_d    = issue & hz.id_fpu_reg_write;

        state_d      = state_q;
        cnt_d        = cnt_q;
        slow_rd_d    = slow_rd_q;
        fp_pending_d = fp_pending_q & ~wb_mask;
        unique case (state_q)
            IDLE: begin
                if (slow_issue) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(SLOW_LAT - 1);
                    slow_rd_d = hz.id_rd;
                    fp_pending_d[hz.id_rd] = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    if (slow_issue) begin
                        cnt_d     = CNT_W'(SLOW_LAT - 1);
                        slow_rd_d = hz.id_rd;
                        fp_pending_d[hz.id_rd] = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            slow_rd_q       <= 5'd0;
            fp_pending_q    <= 32'd0;
            ex_load_valid_q <= 1'b0;
            ex_load_rd_q    <= 5'd0;
            ex_load_fp_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            slow_rd_q       <= slow_rd_d;
            fp_pending_q    <= fp_pending_d;
            ex_load_valid_q <= ex_load_valid_d;
            ex_load_rd_q    <= ex_load_rd_d;
            ex_load_fp_q    <= ex_load_fp_d;
        end
    end

    assign hz.stall      = stall;
    assign hz.issue      = issue;
    assign hz.bubble     = ~issue;
    assign hz.slow_busy  = busy;
    assign hz.slow_wb_en = wb_en;
    assign hz.slow_wb_rd = wb_en ? slow_rd_q : 5'd0;

`ifdef ISSUE_HAZARD_STATS_EN
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [31:0] stat_slow_q, stat_slow_d;

    always_comb begin
        stat_stall_d = stat_stall_q;
        stat_slow_d  = stat_slow_q;
        if (stall && !hz.flush && stat_stall_q != 32'hFFFF_FFFF)
            stat_stall_d = stat_stall_q + 32'd1;
        if (slow_issue && !hz.flush && stat_slow_q != 32'hFFFF_FFFF)
            stat_slow_d = stat_slow_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_stall_q <= 32'd0;
            stat_slow_q  <= 32'd0;
        end else begin
            stat_stall_q <= stat_stall_d;
            stat_slow_q  <= stat_slow_d;
        end
    end

    assign hz.stat_stall_cycles = stat_stall_q;
    assign hz.stat_slow_ops     = stat_slow_q;
`endif
endmodule
